// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM state
// encodings, stream framing constants and the word address helper.
package inst_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // S_DRAIN covers the final write strobe so that done lands one cycle after it.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_ERR,
    S_FIN,
    S_DRAIN
  } state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus of the loader.
// master = stream source / memory side, slave = the loader itself.
interface inst_loader_if;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] Inst_addr_load;
  logic [31:0] Inst_load;
  logic        load_en;

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, Inst_addr_load, Inst_load, load_en
  );

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, Inst_addr_load, Inst_load, load_en
  );
endinterface

// File: rtl/inst_loader_byte_packer.sv
// Little-endian byte packer: collects bytes 0..2 in slot registers and
// publishes the full word (with byte 3) into a separate output register.
module inst_loader_byte_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);
  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0]                     cnt_q;
  logic [8*(BYTES_PER_WORD-1)-1:0]   slots;
  logic [31:0]                       word_q;
  logic                              word_valid_q;

  assign last_byte_o  = (cnt_q == CW'(BYTES_PER_WORD - 1));
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_slot
      logic [7:0] slot_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_q <= 8'h00;
        end else if (en_i && !clr_i && cnt_q == CW'(gi)) begin
          slot_q <= byte_i;
        end
      end
      assign slots[8*gi +: 8] = slot_q;
    end
  endgenerate

  // The output word is separate from the slots, so the next word can start
  // filling while the completed one is being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      word_q       <= 32'h0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= en_i && !clr_i && last_byte_o;
      if (clr_i) begin
        cnt_q <= '0;
      end else if (en_i) begin
        cnt_q <= cnt_q + CW'(1);
        if (last_byte_o) begin
          word_q <= {byte_i, slots};
        end
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot-time program loader: header parse, word packing and instruction-memory
// writes. Optional trailing XOR checksum with INST_LOADER_CHECKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024,
  parameter int          CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  inst_loader_if.slave bus,
  output logic         core_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_e            state_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  idx_q;
  logic [7:0]        len_lo_q;
  logic [31:0]       addr_q;
  logic              core_hold_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              hs;
  logic              data_hs;
  logic              pk_last;
  logic [CNT_W-1:0]  hdr_n;

  assign bus.byte_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                          (state_q == S_DATA) || (state_q == S_CSUM);
  assign hs             = bus.byte_valid && bus.byte_ready;
  assign data_hs        = hs && (state_q == S_DATA);
  assign hdr_n          = CNT_W'({bus.byte_data, len_lo_q});

  assign bus.Inst_addr_load = addr_q;
  assign core_hold          = core_hold_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;

  inst_loader_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start && state_q == S_IDLE),
    .en_i         (data_hs),
    .byte_i       (bus.byte_data),
    .last_byte_o  (pk_last),
    .word_o       (bus.Inst_load),
    .word_valid_o (bus.load_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      len_lo_q    <= 8'h00;
      addr_q      <= 32'h0;
      core_hold_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LEN0;
            core_hold_q <= 1'b1;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            idx_q       <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
          end
        end
        S_LEN0: begin
          if (hs) begin
            len_lo_q <= bus.byte_data;
            state_q  <= S_LEN1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q   <= csum_q ^ bus.byte_data;
`endif
          end
        end
        S_LEN1: begin
          if (hs) begin
            n_q <= hdr_n;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.byte_data;
`endif
            if (int'(hdr_n) > MAX_WORDS) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else if (hdr_n == '0) begin
`ifdef INST_LOADER_CHECKSUM_EN
              state_q     <= S_CSUM;
`else
              state_q     <= S_FIN;
              done_q      <= 1'b1;
              core_hold_q <= 1'b0;
`endif
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (hs) begin
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.byte_data;
`endif
            // Address is latched alongside the packer's word so both appear with load_en.
            if (pk_last) begin
              addr_q <= word_addr(BASE_ADDR, 32'(idx_q));
              idx_q  <= idx_q + CNT_W'(1);
              if (idx_q + CNT_W'(1) == n_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                state_q <= S_CSUM;
`else
                state_q <= S_DRAIN;
`endif
              end
            end
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (hs) begin
            if (bus.byte_data != csum_q) begin
              err_q <= 1'b1;
            end
            state_q     <= S_FIN;
            done_q      <= 1'b1;
            core_hold_q <= 1'b0;
          end
        end
`endif
        S_DRAIN, S_ERR: begin
          state_q     <= S_FIN;
          done_q      <= 1'b1;
          core_hold_q <= 1'b0;
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader; trailing checksum bytes are added and
// checked when INST_LOADER_CHECKSUM_EN is defined.
module tb_inst_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic core_hold, busy, done, err;

  inst_loader_if bus();

  inst_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_evt = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_err[$];
  int          exp_lat[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals done.
  initial begin
    logic [31:0] a, d;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (bus.byte_valid && bus.byte_ready) last_evt = cyc;
        if (bus.load_en) begin
          last_evt = cyc;
          if (exp_addr.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write: got %h@%h expected none", bus.Inst_load, bus.Inst_addr_load);
          end else begin
            a = exp_addr.pop_front();
            d = exp_data.pop_front();
            $display("write %h @ %h", bus.Inst_load, bus.Inst_addr_load);
            chk("write_addr", bus.Inst_addr_load, a);
            chk("write_data", bus.Inst_load, d);
            chk("hold_during_write", 32'(core_hold), 32'd1);
          end
        end
        if (done) begin
          if (exp_err.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got done=1 expected none");
          end else begin
            int lat;
            bit e;
            e   = exp_err.pop_front();
            lat = exp_lat.pop_front();
            $display("done err=%0d latency=%0d", err, cyc - last_evt);
            chk("done_err", 32'(err), 32'(e));
            chk("done_hold_low", 32'(core_hold), 32'd0);
            chk("done_latency", 32'(cyc - last_evt), 32'(lat));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    bit got;
    repeat (gap) begin
      bus.byte_valid = 1'b0;
      tick();
    end
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      got = bus.byte_ready;
      tick();
    end
    bus.byte_valid = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL byte_timeout: got ready=0 expected ready within 50 cycles");
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 64 && !idle; t++) begin
      tick();
      idle = !busy;
    end
    if (!idle) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 64 cycles");
    end
  endtask

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
  task automatic run_image(input int n, input logic [7:0] data[$], input int mode,
                           input bit poke, input logic [7:0] csum_flip);
    logic [7:0]  stream[$];
    logic [15:0] nn;
    logic [7:0]  x;
    logic [31:0] w;
    bit          bad;
    int          gap;
    nn = 16'(n);
    stream.push_back(nn[7:0]);
    stream.push_back(nn[15:8]);
    bad = (n > MAXW);
    if (n <= MAXW) begin
      foreach (data[i]) stream.push_back(data[i]);
      for (int k = 0; k < n; k++) begin
        w = 32'h0;
        for (int b = 0; b < 4; b++) w += 32'(data[4*k+b]) << (8*b);
        exp_addr.push_back(BASE + 32'(4*k));
        exp_data.push_back(w);
      end
`ifdef INST_LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (stream[i]) x ^= stream[i];
      stream.push_back(x ^ csum_flip);
      bad = (csum_flip != 8'h00);
`else
      x = csum_flip;
`endif
    end
    exp_err.push_back(bad);
    exp_lat.push_back((n > MAXW) ? 2 : 1);
    $display("image n=%0d bytes=%0d mode=%0d poke=%0d", n, stream.size(), mode, poke);
    start_pulse();
    chk("hold_after_start", 32'(core_hold), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
    foreach (stream[i]) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      if (poke && i == 3) start = 1'b1;
      drive_byte(stream[i], gap);
      start = 1'b0;
    end
    wait_idle();
    chk("err_sticky", 32'(err), 32'(bad));
    chk("hold_idle", 32'(core_hold), 32'd0);
  endtask

  initial begin
    logic [7:0] img[$];
    logic [7:0] rnd[$];
    int n;
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_hold", 32'(core_hold), 32'd0);
    chk("idle_addr", bus.Inst_addr_load, 32'h0);
    chk("idle_load_en", 32'(bus.load_en), 32'd0);

    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h33, 8'h81, 8'h20, 8'h00};
    run_image(3, img, 0, 1'b0, 8'h00);
    run_image(3, img, 1, 1'b1, 8'h00);
    rnd = {};
    run_image(2049, rnd, 0, 1'b0, 8'h00);
    run_image(0, rnd, 0, 1'b0, 8'h00);

    // Abort after 6 data bytes: only word 0 reaches memory.
    exp_addr.push_back(BASE);
    exp_data.push_back(32'h0000_0013);
    start_pulse();
    drive_byte(8'h03, 0);
    drive_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) drive_byte(img[i], 0);
    rst = 1'b1;
    tick();
    chk("abort_hold", 32'(core_hold), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err_done", {30'd0, err, done}, 32'd0);
    chk("abort_bus", {30'd0, bus.load_en, bus.byte_ready}, 32'd0);
    chk("abort_addr", bus.Inst_addr_load, 32'h0);
    chk("abort_data", bus.Inst_load, 32'h0);
    rst = 1'b0;
    tick();
    img = '{8'h93, 8'h00, 8'h10, 8'h00};
    run_image(1, img, 0, 1'b0, 8'h00);

`ifdef INST_LOADER_CHECKSUM_EN
    img = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_image(1, img, 0, 1'b0, 8'h00);
    run_image(1, img, 0, 1'b0, 8'h12);
`endif

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 6));
      rnd = {};
      for (int i = 0; i < 4*n; i++) rnd.push_back(8'($urandom));
      run_image(n, rnd, 2, 1'($urandom), 8'h00);
    end

    repeat (3) tick();
    chk("writes_left", 32'(exp_addr.size()), 32'd0);
    chk("dones_left", 32'(exp_err.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
